// File: rtl/alu_flags_stage.sv
// EX/MEM stage register with NZCV flag generation for the bit-slice ALU chain.
// Flags update only on accepted flag-setting ops; invalid flag requests pulse illegal_op.
module alu_flags_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [2:0]       cntrl,
    input  logic             carry_out,
    input  logic             carry_msb_in,
    input  logic             set_flags,
    input  logic [4:0]       rd_in,
    input  logic             reg_write_in,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] result_q,
    output logic [4:0]       rd_q,
    output logic             reg_write_q,
    output logic             valid_q,
    output logic [3:0]       nzcv_q,
    output logic             illegal_op
);
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    // Zero detect as an explicit 4-ary OR tree; each level is zero-padded to a multiple of 4.
    localparam int W1 = (WIDTH + 3) / 4;
    localparam int W2 = (W1 + 3) / 4;
    localparam int W3 = (W2 + 3) / 4;
    localparam int W4 = (W3 + 3) / 4;
    localparam int P0 = 4 * W1;
    localparam int P1 = 4 * W2;
    localparam int P2 = 4 * W3;
    localparam int P3 = 4 * W4;

    logic [P0-1:0] z_p0;
    logic [W1-1:0] z_l1;
    logic [P1-1:0] z_p1;
    logic [W2-1:0] z_l2;
    logic [P2-1:0] z_p2;
    logic [W3-1:0] z_l3;
    logic [P3-1:0] z_p3;
    logic [W4-1:0] z_l4;
    logic          zero;

    assign z_p0 = P0'(alu_result);
    assign z_p1 = P1'(z_l1);
    assign z_p2 = P2'(z_l2);
    assign z_p3 = P3'(z_l3);

    generate
        for (genvar i = 0; i < W1; i++) begin : g_l1
            assign z_l1[i] = |z_p0[4*i +: 4];
        end
        for (genvar i = 0; i < W2; i++) begin : g_l2
            assign z_l2[i] = |z_p1[4*i +: 4];
        end
        for (genvar i = 0; i < W3; i++) begin : g_l3
            assign z_l3[i] = |z_p2[4*i +: 4];
        end
        for (genvar i = 0; i < W4; i++) begin : g_l4
            assign z_l4[i] = |z_p3[4*i +: 4];
        end
    endgenerate

    assign zero = ~(|z_l4);

    logic             accept;
    logic             arith;
    logic             flag_op;
    logic [3:0]       nzcv_d;
    logic [WIDTH-1:0] result_d;
    logic [4:0]       rd_d;
    logic             reg_write_d;
    logic             valid_d;
    logic             illegal_d;
    logic             illegal_q;

    always_comb begin
        accept      = valid_in & ~stall & ~flush;
        arith       = (cntrl == OP_ADD) || (cntrl == OP_SUB);
        flag_op     = arith || (cntrl == OP_AND) || (cntrl == OP_OR) || (cntrl == OP_XOR);
        result_d    = result_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        valid_d     = valid_q;
        nzcv_d      = nzcv_q;
        illegal_d   = 1'b0;

        // Flush wins over stall; a bubble (valid_in low) clears the write side only.
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (!stall) begin
            if (valid_in) begin
                result_d    = alu_result;
                rd_d        = rd_in;
                reg_write_d = reg_write_in;
                valid_d     = 1'b1;
            end else begin
                valid_d     = 1'b0;
                reg_write_d = 1'b0;
            end
        end

        if (accept && set_flags) begin
            if (flag_op)
                nzcv_d = {alu_result[WIDTH-1], zero, arith & carry_out,
                          arith & (carry_out ^ carry_msb_in)};
            else
                illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            valid_q     <= 1'b0;
            nzcv_q      <= 4'b0000;
            illegal_q   <= 1'b0;
        end else begin
            result_q    <= result_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            valid_q     <= valid_d;
            nzcv_q      <= nzcv_d;
            illegal_q   <= illegal_d;
        end
    end

    assign illegal_op = illegal_q;
endmodule

// File: tb/tb_alu_flags_stage.sv
// Table of directed vectors for the corner cases, then random operands checked
// against an arithmetic reference model of the flag and stage-register rules.
module tb_alu_flags_stage;
    localparam int W = 64;

    logic          clk = 1'b0;
    logic          reset_n, valid_in, carry_out, carry_msb_in, set_flags;
    logic          reg_write_in, stall, flush;
    logic [W-1:0]  alu_result;
    logic [2:0]    cntrl;
    logic [4:0]    rd_in;
    logic [W-1:0]  result_q;
    logic [4:0]    rd_q;
    logic          reg_write_q, valid_q, illegal_op;
    logic [3:0]    nzcv_q;

    int checks = 0;
    int failures = 0;

    alu_flags_stage #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .alu_result(alu_result),
        .cntrl(cntrl), .carry_out(carry_out), .carry_msb_in(carry_msb_in),
        .set_flags(set_flags), .rd_in(rd_in), .reg_write_in(reg_write_in),
        .stall(stall), .flush(flush), .result_q(result_q), .rd_q(rd_q),
        .reg_write_q(reg_write_q), .valid_q(valid_q), .nzcv_q(nzcv_q),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n, vld, stl, fls, sf;
        logic [2:0]   op;
        logic [W-1:0] res;
        logic         co, cm;
        logic [4:0]   rd;
        logic         rw;
        logic         e_vld, e_rw;
        logic [4:0]   e_rd;
        logic [W-1:0] e_res;
        logic [3:0]   e_nzcv;
        logic         e_ill;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst_n, logic vld, logic stl, logic fls, logic sf,
                                logic [2:0] op, logic [W-1:0] res, logic co, logic cm,
                                logic [4:0] rd, logic rw, logic e_vld, logic e_rw,
                                logic [4:0] e_rd, logic [W-1:0] e_res, logic [3:0] e_nzcv,
                                logic e_ill);
        vec_t v;
        v.rst_n = rst_n; v.vld = vld; v.stl = stl; v.fls = fls; v.sf = sf; v.op = op;
        v.res = res; v.co = co; v.cm = cm; v.rd = rd; v.rw = rw;
        v.e_vld = e_vld; v.e_rw = e_rw; v.e_rd = e_rd; v.e_res = e_res;
        v.e_nzcv = e_nzcv; v.e_ill = e_ill;
        return v;
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst_n, logic vld, logic stl, logic fls, logic sf,
                         logic [2:0] op, logic [W-1:0] res, logic co, logic cm,
                         logic [4:0] rd, logic rw);
        @(negedge clk);
        reset_n = rst_n; valid_in = vld; stall = stl; flush = fls; set_flags = sf;
        cntrl = op; alu_result = res; carry_out = co; carry_msb_in = cm;
        rd_in = rd; reg_write_in = rw;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [W-1:0] m_res;
    logic [4:0]   m_rd;
    logic         m_rw, m_vld, m_ill;
    logic [3:0]   m_nzcv;

    localparam logic [W-1:0] H8 = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES = '1;

    initial begin
        reset_n = 0; valid_in = 0; stall = 0; flush = 0; set_flags = 0; cntrl = 0;
        alu_result = 0; carry_out = 0; carry_msb_in = 0; rd_in = 0; reg_write_in = 0;

        //            rst vld stl fls sf op  res      co cm rd  rw | vld rw rd  res   nzcv ill
        tbl.push_back(mk(0, 1, 0, 0, 1, 2, 64'h1234, 1, 1, 1, 1,   0, 0, 0,  0,    4'h0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 3, 0,        1, 1, 3, 1,   1, 1, 3,  0,    4'h6, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 2, H8,       0, 1, 4, 1,   1, 1, 4,  H8,   4'h9, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 2, 1,        1, 0, 5, 0,   1, 0, 5,  1,    4'h3, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 4, 0,        1, 0, 6, 1,   1, 1, 6,  0,    4'h4, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2, 64'hF,    1, 1, 7, 1,   1, 1, 7,  64'hF, 4'h4, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 2, 64'h100,  1, 0, 9, 0,   1, 1, 7,  64'hF, 4'h4, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 3, 0,        1, 1, 10, 0,  1, 1, 7,  64'hF, 4'h4, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 6, H8,       0, 0, 11, 1,  1, 1, 7,  64'hF, 4'h4, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 2, 0,        1, 1, 12, 1,  0, 0, 7,  64'hF, 4'h4, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 7, 64'hAA,   1, 0, 13, 1,  1, 1, 13, 64'hAA, 4'h4, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0,        1, 1, 20, 1,  0, 0, 13, 64'hAA, 4'h4, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 64'h55,   0, 0, 14, 0,  1, 0, 14, 64'h55, 4'h4, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 2, 0,        1, 1, 21, 1,  0, 0, 0,  0,    4'h0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 3, 5,        1, 1, 15, 0,  1, 0, 15, 5,    4'h2, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 2, 64'h99,   0, 1, 16, 1,  0, 0, 15, 5,    4'h2, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 6, ONES,     1, 1, 17, 1,  1, 1, 17, ONES, 4'h8, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 5, 0,        1, 0, 18, 1,  1, 1, 18, 0,    4'h4, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 64'h33,   0, 0, 19, 1,  1, 1, 19, 64'h33, 4'h4, 1));
        tbl.push_back(mk(1, 1, 1, 0, 1, 7, 0,        0, 0, 22, 1,  1, 1, 19, 64'h33, 4'h4, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v = tbl[i];
            drive(v.rst_n, v.vld, v.stl, v.fls, v.sf, v.op, v.res, v.co, v.cm, v.rd, v.rw);
            chk($sformatf("row%0d.valid_q", i), W'(valid_q), W'(v.e_vld));
            chk($sformatf("row%0d.reg_write_q", i), W'(reg_write_q), W'(v.e_rw));
            chk($sformatf("row%0d.rd_q", i), W'(rd_q), W'(v.e_rd));
            chk($sformatf("row%0d.result_q", i), result_q, v.e_res);
            chk($sformatf("row%0d.nzcv_q", i), W'(nzcv_q), W'(v.e_nzcv));
            chk($sformatf("row%0d.illegal_op", i), W'(illegal_op), W'(v.e_ill));
        end

        // Random phase: operands are generated, the ALU chain's outputs are derived from them,
        // and expected flags come from unsigned/signed comparisons of the operands.
        m_res = 0; m_rd = 0; m_rw = 0; m_vld = 0; m_nzcv = 0; m_ill = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] a, b, r;
            logic [W:0]   s65;
            logic [W-1:0] s64;
            logic         co, cm, rst_n, vld, stl, fls, sf, rw, eC, eV, acc;
            logic [2:0]   op;
            logic [4:0]   rd;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) b = a;
            op = 3'($urandom_range(0, 7));
            co = 1'($urandom); cm = 1'($urandom);
            eC = 0; eV = 0;
            case (op)
                3'd0: r = b;
                3'd2: begin
                    s65 = {1'b0, a} + {1'b0, b};
                    s64 = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]};
                    r = s65[W-1:0]; co = s65[W]; cm = s64[W-1];
                    eC = ({1'b0, a} + {1'b0, b}) > {1'b0, ONES};
                    eV = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
                end
                3'd3: begin
                    s65 = {1'b0, a} + {1'b0, ~b} + 65'd1;
                    s64 = {1'b0, a[W-2:0]} + {1'b0, ~b[W-2:0]} + 64'd1;
                    r = a - b; co = s65[W]; cm = s64[W-1];
                    eC = (a >= b);
                    eV = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
                end
                3'd4: r = a & b;
                3'd5: r = ($urandom_range(0, 3) == 0) ? '0 : (a | b);
                3'd6: r = a ^ b;
                default: r = a;
            endcase
            rst_n = ($urandom_range(0, 40) != 0);
            vld = ($urandom_range(0, 3) != 0);
            stl = ($urandom_range(0, 4) == 0);
            fls = ($urandom_range(0, 6) == 0);
            sf = 1'($urandom);
            rw = 1'($urandom);
            rd = 5'($urandom);
            drive(rst_n, vld, stl, fls, sf, op, r, co, cm, rd, rw);

            acc = vld && !stl && !fls;
            if (!rst_n) begin
                m_res = 0; m_rd = 0; m_rw = 0; m_vld = 0; m_nzcv = 0; m_ill = 0;
            end else begin
                m_ill = 0;
                if (fls) begin
                    m_vld = 0; m_rw = 0;
                end else if (!stl) begin
                    m_vld = vld; m_rw = vld && rw;
                    if (vld) begin m_res = r; m_rd = rd; end
                end
                if (acc && sf) begin
                    if (op >= 3'd2 && op <= 3'd6)
                        m_nzcv = {$signed(r) < 0, r == 0, eC, eV};
                    else
                        m_ill = 1;
                end
            end
            chk($sformatf("rnd%0d.valid_q", n), W'(valid_q), W'(m_vld));
            chk($sformatf("rnd%0d.reg_write_q", n), W'(reg_write_q), W'(m_rw));
            chk($sformatf("rnd%0d.rd_q", n), W'(rd_q), W'(m_rd));
            chk($sformatf("rnd%0d.result_q", n), result_q, m_res);
            chk($sformatf("rnd%0d.nzcv_q", n), W'(nzcv_q), W'(m_nzcv));
            chk($sformatf("rnd%0d.illegal_op", n), W'(illegal_op), W'(m_ill));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
